// File: rtl/chunked_extend_adder_pkg.sv
// Shared definitions for the chunked adders: FSM states, chunk-count helper
// and the parameter legality check.
package chunked_extend_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  function automatic bit params_legal(input int width_a, input int width_b, input int chunk);
    return (width_b >= 1) && (width_b <= width_a) && (chunk >= 1) && (chunk <= width_a);
  endfunction

endpackage

// File: rtl/chunked_extend_adder_chunk_add_slice.sv
// Combinational W-bit adder slice with carry in/out; kept separate so a
// carry-lookahead slice can drop in later.
module chunk_add_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] s_o,
  output logic         cout_o
);

  assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};

endmodule

// File: rtl/chunked_extend_adder.sv
// Multi-cycle a + zero_ext(b), CHUNK bits per cycle, LSB first, with early
// exit once b is consumed and the carry has died out.
//
// state  | meaning
// S_IDLE | waiting for operands, in_ready high
// S_ADD  | adding chunk k_q with carry_q
// S_DONE | sum held, out_valid high until out_ready
module chunked_extend_adder
  import chunked_extend_adder_pkg::*;
#(
  parameter int WIDTH_A = 53,
  parameter int WIDTH_B = 8,
  parameter int CHUNK   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_A-1:0] a,
  input  logic [WIDTH_B-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_A:0]   sum,
  output logic               early_exit
);

  localparam int NCHUNK = ceil_div(WIDTH_A, CHUNK);
  localparam int PADW   = NCHUNK * CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (!params_legal(WIDTH_A, WIDTH_B, CHUNK)) begin : g_bad_params
    $error("chunked_extend_adder: need 1 <= WIDTH_B <= WIDTH_A and 1 <= CHUNK <= WIDTH_A");
  end

  state_e          state_q;
  logic [PADW-1:0] a_q, b_q;
  logic [PADW:0]   res_q, res_d;
  logic [KW-1:0]   k_q;
  logic            carry_q;
  logic            in_ready_q, out_valid_q, early_q;

  logic [PADW-1:0]  a_pad, b_pad;
  logic [CHUNK-1:0] a_sl, b_sl, s_sl;
  logic             cout;
  logic             last_chunk, exit_ok;

  always_comb begin
    a_pad = '0;
    a_pad[WIDTH_A-1:0] = a;
    b_pad = '0;
    b_pad[WIDTH_B-1:0] = b;
  end

  assign a_sl = a_q[int'(k_q)*CHUNK +: CHUNK];
  assign b_sl = b_q[int'(k_q)*CHUNK +: CHUNK];

  chunk_add_slice #(.W(CHUNK)) u_slice (
    .a_i    (a_sl),
    .b_i    (b_sl),
    .cin_i  (carry_q),
    .s_o    (s_sl),
    .cout_o (cout)
  );

  assign last_chunk = (int'(k_q) == NCHUNK - 1);
  // A carry leaving the chunk that finishes b still has to be added in.
  assign exit_ok    = ((int'(k_q) + 1) * CHUNK >= WIDTH_B) && !cout;

  always_comb begin
    res_d = res_q;
    for (int j = 0; j < NCHUNK; j++) begin
      if (j == int'(k_q)) begin
        res_d[j*CHUNK +: CHUNK] = s_sl;
      end else if (!last_chunk && exit_ok && (j > int'(k_q))) begin
        res_d[j*CHUNK +: CHUNK] = a_q[j*CHUNK +: CHUNK];
      end
    end
    if (last_chunk) res_d[PADW] = cout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      k_q         <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      early_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q        <= a_pad;
            b_q        <= b_pad;
            res_q      <= '0;
            k_q        <= '0;
            carry_q    <= 1'b0;
            early_q    <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= S_ADD;
          end
        end
        S_ADD: begin
          res_q   <= res_d;
          carry_q <= cout;
          if (last_chunk) begin
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (exit_ok) begin
            early_q     <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign early_exit = early_q;
  assign sum        = res_q[WIDTH_A:0];

endmodule

// File: tb/tb_chunked_extend_adder.sv
// Self-checking bench for chunked_extend_adder: arithmetic reference model
// with a per-cycle monitor, plus directed vectors with literal expectations.
module tb_chunked_extend_adder;

  localparam int WA  = 53;
  localparam int WB  = 8;
  localparam int CH  = 16;
  localparam int NCH = (WA + CH - 1) / CH;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [WA-1:0] a;
  logic [WB-1:0] b;
  logic          out_valid, out_ready;
  logic [WA:0]   sum;
  logic          early_exit;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    logic [WA:0] exp_sum;
    bit          exp_early;
    int          exp_lat;
    int          acc_cyc;
    bit          seen;
  } op_t;
  op_t q[$];

  chunked_extend_adder #(.WIDTH_A(WA), .WIDTH_B(WB), .CHUNK(CH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .early_exit (early_exit)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Chunk cycles used: stop after chunk k-1 once b is fully covered by k chunks
  // and the low k*CH bits of a+b produce no carry beyond them.
  function automatic int model_chunks(input logic [WA-1:0] av, input logic [WB-1:0] bv);
    longint unsigned mask, s;
    for (int k = 1; k < NCH; k++) begin
      mask = (64'd1 << (k * CH)) - 64'd1;
      s = (64'(av) & mask) + 64'(bv);
      if ((k * CH >= WB) && (((s >> (k * CH)) & 64'd1) == 64'd0)) return k;
    end
    return NCH;
  endfunction

  function automatic logic [WA:0] model_sum(input logic [WA-1:0] av, input logic [WB-1:0] bv);
    return (WA+1)'(av) + (WA+1)'(bv);
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      chk(!out_valid, "rst_out_valid", 64'(out_valid), 64'd0);
      chk(in_ready, "rst_in_ready", 64'(in_ready), 64'd1);
      chk(sum == '0, "rst_sum", 64'(sum), 64'd0);
    end else begin
      if (q.size() > 0) begin
        chk(!in_ready, "busy_in_ready", 64'(in_ready), 64'd0);
        if (out_valid) begin
          chk(sum == q[0].exp_sum, "mon_sum", 64'(sum), 64'(q[0].exp_sum));
          chk(early_exit == q[0].exp_early, "mon_early", 64'(early_exit), 64'(q[0].exp_early));
          if (!q[0].seen) begin
            chk(cyc - q[0].acc_cyc == q[0].exp_lat, "mon_latency",
                64'(cyc - q[0].acc_cyc), 64'(q[0].exp_lat));
            q[0].seen = 1'b1;
          end
          if (out_ready) void'(q.pop_front());
        end
      end else begin
        chk(!out_valid, "spurious_valid", 64'(out_valid), 64'd0);
        chk(in_ready, "idle_in_ready", 64'(in_ready), 64'd1);
      end
      if (in_valid && in_ready) begin
        op_t o;
        o.exp_sum   = model_sum(a, b);
        o.exp_lat   = model_chunks(a, b) + 1;
        o.exp_early = (model_chunks(a, b) < NCH);
        o.acc_cyc   = cyc;
        o.seen      = 1'b0;
        q.push_back(o);
      end
    end
  end

  // Present operands until accepted; returns at accept edge + #1.
  task automatic send(input logic [WA-1:0] av, input logic [WB-1:0] bv);
    bit got = 0;
    in_valid = 1'b1;
    a = av;
    b = bv;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1;
    end
    if (!got) chk(0, "accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called just after the accept edge; latency counts the accept edge as 1.
  task automatic wait_out(input logic [WA:0] es, input bit ee, input int el);
    int edges = 0;
    while (!out_valid && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    if (!out_valid) chk(0, "out_timeout", 64'd0, 64'd1);
    chk(edges + 1 == el, "lit_latency", 64'(edges + 1), 64'(el));
    chk(sum == es, "lit_sum", 64'(sum), 64'(es));
    chk(early_exit == ee, "lit_early", 64'(early_exit), 64'(ee));
  endtask

  task automatic pulse_ready();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [WA-1:0] av, input logic [WB-1:0] bv,
                        input logic [WA:0] es, input bit ee, input int el);
    chk(model_chunks(av, bv) + 1 == el, "model_latency", 64'(model_chunks(av, bv) + 1), 64'(el));
    chk(model_sum(av, bv) == es, "model_sum", 64'(model_sum(av, bv)), 64'(es));
    send(av, bv);
    wait_out(es, ee, el);
    pulse_ready();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    int ops;
    bit pend;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk(in_ready, "post_rst_ready", 64'(in_ready), 64'd1);

    run_op(53'h1F_FFFF_FFFF_FFFF, 8'h01, 54'h20_0000_0000_0000, 1'b0, 5);
    run_op(53'h0000_0000_0100, 8'h05, 54'h105, 1'b1, 2);
    run_op(53'h0000_0000_FFFF, 8'hFF, 54'h1_00FE, 1'b1, 3);
    run_op(53'h0000_FFFF_FFFF, 8'h01, 54'h1_0000_0000, 1'b1, 4);

    // Backpressure: result held, new operand waits for in_ready.
    send(53'h1234_5678, 8'h10);
    wait_out(54'h1234_5688, 1'b1, 2);
    in_valid = 1'b1;
    a = 53'hABCD;
    b = 8'h33;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk(out_valid && sum == 54'h1234_5688 && !in_ready, "hold",
          {8'(out_valid), 8'(in_ready), 48'(sum)}, {8'd1, 8'd0, 48'h1234_5688});
    end
    pulse_ready();
    chk(in_ready, "ready_after_hs", 64'(in_ready), 64'd1);
    send(53'hABCD, 8'h33);
    wait_out(54'hAC00, 1'b1, 2);
    pulse_ready();

    // Reset during ADD at k=1.
    send(53'h1F_FFFF_FFFF_FFFF, 8'h01);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk(!out_valid && in_ready && sum == '0 && !early_exit, "async_rst",
        {8'(out_valid), 8'(in_ready), 8'(early_exit), 40'(sum)}, {8'd0, 8'd1, 8'd0, 40'd0});
    @(posedge clk); #1;
    rst = 1'b0;
    #1 chk(in_ready, "first_post_rst", 64'(in_ready), 64'd1);
    run_op(53'h1, 8'h1, 54'h2, 1'b1, 2);

    // Random valid/ready sweep against the monitor model.
    ops = 0;
    for (int c = 0; c < 12000 && ops < 600; c++) begin
      @(negedge clk);
      pend = in_valid && in_ready;
      @(posedge clk); #1;
      if (pend) ops++;
      if (pend || !in_valid) begin
        r = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0: r[15:0] = 16'hFFFF;
          1: r[31:0] = 32'hFFFF_FFFF;
          2: r = '1;
          default: ;
        endcase
        in_valid = ($urandom_range(0, 3) != 0);
        a = r[WA-1:0];
        b = WB'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
    end
    chk(ops >= 100, "random_ops", 64'(ops), 64'd100);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1 chk(q.size() == 0, "drain", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
